// File: rtl/mult_share_sched.sv
// mult_share_sched
//   Time-shares one signed fixed-point multiplier between N_REQ requesters.
//   A round-robin arbiter accepts at most one operand pair per cycle. The
//   pair goes through a two-stage pipeline (operand register, then result
//   register). The product is narrowed to WI_O.WF_O, saturated on overflow,
//   and tagged with the index of the requester that issued it.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-high reset
//   en         grant enable; 0 stops new grants, in-flight ops still drain
//   req_valid  per-requester operand-pair valid
//   req_ready  one-hot grant, handshake on req_valid & req_ready
//   req_a      packed operand A, requester i at slice i (WI.WF signed)
//   req_b      packed operand B, requester i at slice i (WI.WF signed)
//   res_valid  single-cycle result pulse
//   res_id     requester index of the result
//   res_data   narrowed, saturated product (WI_O.WF_O signed)
//   res_ovf    saturation flag for this result
//   busy       an op is in stage 1 or stage 2
module mult_share_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int WI    = 3,
  parameter int WF    = 5,
  parameter int WI_O  = 3,
  parameter int WF_O  = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*(WI+WF)-1:0]      req_a,
  input  logic [N_REQ*(WI+WF)-1:0]      req_b,
  output logic                          res_valid,
  output logic [ID_W-1:0]               res_id,
  output logic [WI_O+WF_O-1:0]          res_data,
  output logic                          res_ovf,
  output logic                          busy
);

  localparam int W   = WI + WF;          // operand width
  localparam int PW  = 2 * W;            // full product width
  localparam int OW  = WI_O + WF_O;      // result width
  // Fraction alignment: drop SH LSBs, or append PAD zero LSBs.
  localparam int SH  = (WF_O < 2 * WF) ? (2 * WF - WF_O) : 0;
  localparam int PAD = (WF_O > 2 * WF) ? (WF_O - 2 * WF) : 0;
  localparam int EW  = PW + PAD;         // aligned product width

  // ---------------------------------------------------------------------
  // Round-robin arbiter
  // ---------------------------------------------------------------------
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [N_REQ-1:0]     grant;
  logic [ID_W-1:0]      gnt_idx;
  logic                 hs;
  logic signed [W-1:0]  a_sel, b_sel;

  // Two passes replace a modulo rotation: pass 0 scans indices >= ptr,
  // pass 1 wraps around to indices < ptr. First hit wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    hs      = 1'b0;
    a_sel   = '0;
    b_sel   = '0;
    if (en && !rst) begin
      for (int unsigned pass = 0; pass < 2; pass++) begin
        for (int unsigned j = 0; j < N_REQ; j++) begin
          if (!hs && req_valid[j] && ((pass == 0) == (j >= 32'(ptr_q)))) begin
            hs       = 1'b1;
            grant[j] = 1'b1;
            gnt_idx  = ID_W'(j);
            a_sel    = req_a[j*W +: W];
            b_sel    = req_b[j*W +: W];
          end
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      if (gnt_idx == ID_W'(N_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + ID_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------
  logic                 s1_valid_q;
  logic signed [W-1:0]  s1_a_q, s1_b_q;
  logic [ID_W-1:0]      s1_id_q;

  // ---------------------------------------------------------------------
  // Multiply and narrow (between stage 1 and stage 2)
  // ---------------------------------------------------------------------
  logic signed [PW-1:0] prod;
  logic signed [EW-1:0] prod_ext;
  logic signed [EW-1:0] scaled;
  logic signed [EW-1:0] hi;
  logic                 ovf;
  logic [OW-1:0]        sat;
  logic [OW-1:0]        narrow;

  always_comb begin
    prod     = PW'(s1_a_q) * PW'(s1_b_q);
    prod_ext = EW'(prod);
    // Arithmetic right shift truncates toward -inf.
    scaled   = (prod_ext <<< PAD) >>> SH;
    // In range iff every bit from the result sign upward matches.
    hi       = scaled >>> (OW - 1);
    ovf      = !((hi == '0) || (hi == '1));
    sat          = {OW{~scaled[EW-1]}};
    sat[OW-1]    = scaled[EW-1];
    narrow   = ovf ? sat : scaled[OW-1:0];
  end

  // ---------------------------------------------------------------------
  // Stage 2 / output registers
  // ---------------------------------------------------------------------
  logic                 res_valid_q;
  logic [OW-1:0]        res_data_q;
  logic                 res_ovf_q;
  logic [ID_W-1:0]      res_id_q;
  logic                 busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= hs;
      if (hs) begin
        s1_a_q  <= a_sel;
        s1_b_q  <= b_sel;
        s1_id_q <= gnt_idx;
      end
      res_valid_q <= s1_valid_q;
      // Result fields hold between pulses.
      if (s1_valid_q) begin
        res_data_q <= narrow;
        res_ovf_q  <= ovf;
        res_id_q   <= s1_id_q;
      end
      // Registered equivalent of s1_valid | s2_valid.
      busy_q <= hs | s1_valid_q;
    end
  end

  assign req_ready = grant;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;

endmodule

// File: doc/mult_share_sched.md
Name: mult_share_sched

Overview:
- Time-shares one signed fixed-point multiplier between N_REQ requesters, e.g. per-voice gain/envelope multiplies in the synth voice path.
- Round-robin arbiter grants one operand pair per cycle.
- A two-stage pipeline (operand register, result register) returns the narrowed, saturated product tagged with the requester index.
- Sits between the voice/envelope engines and the mixer.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- ID_W, 2, width of result tag; must equal max(1, clog2(N_REQ))
- WI, 3, integer bits of each operand (incl. sign)
- WF, 5, fractional bits of each operand
- WI_O, 3, integer bits of result (1..2*WI)
- WF_O, 5, fractional bits of result (0..2*WF)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  grant enable; 0 = no new grants, in-flight ops drain
- req_valid  in  N_REQ  per-requester operand-pair valid
- req_ready  out  N_REQ  one-hot grant; handshake on valid&ready
- req_a  in  N_REQ*(WI+WF)  packed operand A, requester i at slice i
- req_b  in  N_REQ*(WI+WF)  packed operand B, requester i at slice i
- res_valid  out  1  result valid, single-cycle pulse per op
- res_id  out  ID_W  index of requester that issued the op
- res_data  out  WI_O+WF_O  signed product, saturated on overflow
- res_ovf  out  1  overflow/saturation flag for this result
- busy  out  1  1 while any op is in pipeline stage 1 or 2

Behaviour:
- Reset (async, rst=1): req_ready=0, res_valid=0, res_id=0, res_data=0, res_ovf=0, busy=0.
- Reset also clears the RR pointer to 0, invalidates both pipeline stages and discards in-flight ops.
- Arbitration (combinational):
  - When en=1, req_ready is one-hot for the first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo N_REQ.
  - When en=0 or no request, req_ready=0.
  - req_ready never asserts for a requester whose req_valid=0.
  - No backpressure downstream, so the arbiter grants every cycle a request exists.
- Pointer: on a handshake to index g, ptr <= (g+1) mod N_REQ, wrapping N_REQ-1 -> 0. No handshake: ptr holds.
- Stage 1, edge after handshake: register A, B and the id, and set s1_valid.
- Stage 2, next edge:
  - Form the full (2*WI+2*WF)-bit signed product of the stage-1 operands.
  - Narrow it, then register res_data, res_ovf, res_id, and res_valid=s1_valid.
- Latency: handshake sampled at edge T, so res_valid is high for the cycle following edge T+1. Throughput is 1 op/cycle.
- res_valid is a pulse. Consumer must accept it that cycle; res_data/res_id hold their values when res_valid=0.
- Fraction narrowing:
  - WF_O < 2*WF: truncate LSBs toward -inf (no rounding).
  - WF_O = 2*WF: pass through.
  - WF_O > 2*WF: zero-pad LSBs.
- Integer narrowing:
  - WI_O = 2*WI: no overflow possible.
  - WI_O < 2*WI: ovf=1 when the discarded MSBs are not all equal to the product sign.
  - On ovf, res_data saturates: positive -> 0 followed by all 1s; negative -> 1 followed by all 0s.
  - Without ovf, res_data is the sign bit plus the low WI_O-1 integer bits.
- busy = s1_valid | s2_valid (registered).
- en deassert mid-stream: ops already accepted still complete with normal latency.
- Simultaneous requester changes: grant decision uses only current-cycle req_valid. A requester dropping valid without a handshake loses nothing.

Test Plan:
- Reset mid-op: issue req 0 (0x20*0x20), assert rst the next cycle -> no res_valid ever for that op; all outputs 0; ptr=0 after release.
- Latency/arith, default params: req 2 A=0x30 (1.5), B=0x30 -> res_valid exactly 2 edges after handshake, res_data=0x48 (2.25), res_id=2, res_ovf=0.
- Saturation: A=0x60 (3.0), B=0x60 -> res_data=0x7F, ovf=1. A=0x80 (-4.0), B=0x60 -> res_data=0x80, ovf=1. A=0x80, B=0x80 -> 0x7F, ovf=1.
- Round-robin fairness: all 4 req_valid held high from reset -> grants 0,1,2,3,0,1; res_id follows the same sequence on consecutive cycles.
- Sparse/wrap: only req 1 and 3 valid, ptr=2 -> grant 3, then 1, then 3. Single requester held high -> granted every cycle.
- en gating: en=0 with requests pending -> req_ready=0; ops already in flight still produce res_valid; busy falls to 0 two cycles after the last grant.
